// File: rtl/dev_dip_if.sv
// dev_dip_if: change-event channel between the debounced switch reader and
// its consumer (display driver, CPU bus bridge, ...).
//
// Handshake: evt_valid/evt_data/evt_overrun are driven by the producer and
// stay stable while evt_valid is high. A transfer happens on any rising clk
// edge where evt_valid && evt_ack. evt_ack with evt_valid low is ignored. A
// new event arriving while one is still pending replaces evt_data and raises
// evt_overrun.
//
// Signals:
//   evt_valid   producer -> consumer  a change event is pending
//   evt_data    producer -> consumer  switch value at the most recent change
//   evt_overrun producer -> consumer  a pending event was overwritten
//   evt_ack     consumer -> producer  accept the pending event
interface dev_dip_if #(
  parameter int WIDTH = 8
);
  logic             evt_valid;
  logic [WIDTH-1:0] evt_data;
  logic             evt_overrun;
  logic             evt_ack;

  modport master (
    output evt_valid,
    output evt_data,
    output evt_overrun,
    input  evt_ack
  );

  modport slave (
    input  evt_valid,
    input  evt_data,
    input  evt_overrun,
    output evt_ack
  );
endinterface

// File: rtl/dev_dip.sv
// dev_dip: debounced reader for a bank of active-low DIP switches/buttons.
// Raw pins pass a two-flop synchroniser, are sampled on a slow prescaler
// tick and filtered per bit: a bit only changes after STABLE_TICKS
// consecutive samples that differ from the accepted value. Every change is
// announced by a one-cycle sw_changed pulse and a single-entry event on the
// evt channel.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   dip_pins    raw switch pins, asynchronous, low = switch on
//   sw_val      debounced value, 1 = switch on
//   sw_changed  one-cycle pulse in the first cycle sw_val holds a new value
//   evt         change-event channel (master side), see dev_dip_if
module dev_dip #(
  parameter int WIDTH        = 8,
  parameter int TICK_DIV     = 12000,
  parameter int STABLE_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dip_pins,
  output logic [WIDTH-1:0] sw_val,
  output logic             sw_changed,
  dev_dip_if.master        evt
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = ($clog2(STABLE_TICKS + 1) > 0) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] C_LAST = CW'(STABLE_TICKS - 1);

  // Synchroniser resets to all-ones so switches read "off" until the pins
  // have actually been sampled.
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  logic [PW-1:0]    r_presc;
  logic             w_tick;

  logic [CW-1:0]    r_cnt      [WIDTH];
  logic [CW-1:0]    w_cnt_next [WIDTH];
  logic [WIDTH-1:0] r_sw_val;
  logic [WIDTH-1:0] w_sw_next;
  logic [WIDTH-1:0] w_d;
  logic             w_update;

  logic             r_sw_changed;
  logic             r_evt_valid;
  logic [WIDTH-1:0] r_evt_data;
  logic             r_evt_overrun;

  // ---------------------------------------------------------------- sync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= dip_pins;
      r_sync2 <= r_sync1;
    end
  end

  // ----------------------------------------------------------- prescaler
  assign w_tick = (r_presc == P_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // -------------------------------------------------------------- filter
  // Pins are active-low; invert once so the filter works in "1 = on".
  assign w_d = ~r_sync2;

  always_comb begin
    w_sw_next = r_sw_val;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_next[i] = r_cnt[i];
    end
    if (w_tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_d[i] != r_sw_val[i]) begin
          if (r_cnt[i] == C_LAST) begin
            w_sw_next[i]  = w_d[i];
            w_cnt_next[i] = '0;
          end else begin
            w_cnt_next[i] = r_cnt[i] + 1'b1;
          end
        end else begin
          // A sample agreeing with the accepted value throws away progress.
          w_cnt_next[i] = '0;
        end
      end
    end
  end

  // Any bit flipping on this edge makes it an update edge; several bits
  // flipping together still count as one update.
  assign w_update = (w_sw_next != r_sw_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_val     <= '0;
      r_sw_changed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sw_val     <= w_sw_next;
      r_sw_changed <= w_update;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

  // ------------------------------------------------------- event channel
  // Newest value always wins: an update overwrites evt_data even if the
  // previous event was never acknowledged, and flags that loss as overrun
  // unless the old event is being acked on the very same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_valid   <= 1'b0;
      r_evt_data    <= '0;
      r_evt_overrun <= 1'b0;
    end else if (w_update) begin
      r_evt_data  <= w_sw_next;
      r_evt_valid <= 1'b1;
      if (!r_evt_valid || evt.evt_ack) begin
        r_evt_overrun <= 1'b0;
      end else begin
        r_evt_overrun <= 1'b1;
      end
    end else if (r_evt_valid && evt.evt_ack) begin
      r_evt_valid   <= 1'b0;
      r_evt_overrun <= 1'b0;
    end
  end

  // ------------------------------------------------------------- outputs
  assign sw_val          = r_sw_val;
  assign sw_changed      = r_sw_changed;
  assign evt.evt_valid   = r_evt_valid;
  assign evt.evt_data    = r_evt_data;
  assign evt.evt_overrun = r_evt_overrun;

endmodule

// File: tb/tb_dev_dip.sv
module tb_dev_dip;

  localparam int W  = 8;
  localparam int TD = 4;
  localparam int ST = 3;

  // ------------------------------------------------------ clock / reset
  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] dip_pins;
  logic [W-1:0] sw_val;
  logic         sw_changed;

  always #5 clk = ~clk;

  dev_dip_if #(.WIDTH(W)) evt_if ();

  dev_dip #(.WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dip_pins   (dip_pins),
    .sw_val     (sw_val),
    .sw_changed (sw_changed),
    .evt        (evt_if)
  );

  int n_checks = 0;
  int n_err    = 0;
  int chg_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------ reference model
  // Behavioural view: the filter sees the pin value from two edges ago at
  // every TD-th edge after reset; a bit accepts a new value once the last ST
  // samples all disagree with its accepted value.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] ph[$];
  logic [W-1:0] samp_q[$];
  int           tcnt    = 0;
  logic [W-1:0] m_sw    = '0;
  logic         m_chg   = 1'b0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  logic         m_ovr   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic [W-1:0] s;
    logic [W-1:0] nsw;
    bit           all_diff;
    if (!rst_n) begin
      ph      = {8'hFF, 8'hFF};
      samp_q  = {};
      exp_q   = {};
      tcnt    = 0;
      m_sw    = '0;
      m_chg   = 1'b0;
      m_valid = 1'b0;
      m_data  = '0;
      m_ovr   = 1'b0;
    end else begin
      s = ph.pop_front();
      ph.push_back(dip_pins);
      nsw = m_sw;
      if (tcnt == TD - 1) begin
        samp_q.push_back(~s);
        if (samp_q.size() > ST) void'(samp_q.pop_front());
        if (samp_q.size() == ST) begin
          for (int i = 0; i < W; i++) begin
            all_diff = 1'b1;
            foreach (samp_q[k]) begin
              logic [W-1:0] v;
              v = samp_q[k];
              if (v[i] == m_sw[i]) all_diff = 1'b0;
            end
            if (all_diff) nsw[i] = ~m_sw[i];
          end
        end
      end
      tcnt = (tcnt + 1) % TD;
      if (nsw != m_sw) begin
        exp_q.push_back(nsw);
        m_ovr   = (m_valid && !evt_if.evt_ack);
        m_valid = 1'b1;
        m_data  = nsw;
        m_chg   = 1'b1;
      end else begin
        m_chg = 1'b0;
        if (m_valid && evt_if.evt_ack) begin
          m_valid = 1'b0;
          m_ovr   = 1'b0;
        end
      end
      m_sw = nsw;
    end
  end

  // Predicts, between edges, whether the coming edge will be an update edge.
  function automatic bit will_upd();
    logic [W-1:0] nx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    if (tcnt != TD - 1 || samp_q.size() < ST - 1) return 1'b0;
    nx = ~ph[0];
    a  = samp_q[samp_q.size() - 1];
    b  = samp_q[samp_q.size() - 2];
    for (int i = 0; i < W; i++) begin
      if (a[i] != m_sw[i] && b[i] != m_sw[i] && nx[i] != m_sw[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // ------------------------------------------------------------ monitor
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cycle", 32'({sw_val, sw_changed, evt_if.evt_valid, evt_if.evt_data, evt_if.evt_overrun}),
                   32'({m_sw, m_chg, m_valid, m_data, m_ovr}));
      if (sw_changed) begin
        chg_cnt++;
        if (exp_q.size() == 0) begin
          chk("chg_unexpected", 32'(sw_val), 32'hFFFF_FFFF);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          chk("chg_val", 32'(sw_val), 32'(e));
          chk("chg_evt_data", 32'(evt_if.evt_data), 32'(e));
        end
      end
    end
  end

  // ------------------------------------------------------------ drivers
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse();
    evt_if.evt_ack = 1'b1;
    @(negedge clk);
    evt_if.evt_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------- stimulus
  initial begin
    int c0;
    bit found;
    dip_pins       = 8'hFF;
    evt_if.evt_ack = 1'b0;
    rst_n          = 1'b0;
    cycles(3);
    chk("reset_outs", 32'({sw_val, sw_changed, evt_if.evt_valid, evt_if.evt_data, evt_if.evt_overrun}), 32'h0);
    #1 rst_n = 1'b1;

    // Idle
    cycles(200);
    chk("idle_sw", 32'(sw_val), 32'h00);
    chk("idle_chg", chg_cnt, 0);

    // Single change: must land within 2 + ST*TD cycles
    c0 = chg_cnt;
    dip_pins = 8'hFE;
    found = 1'b0;
    for (int k = 0; k < 2 + ST * TD; k++) begin
      @(negedge clk);
      if (sw_val == 8'h01) begin
        found = 1'b1;
        break;
      end
    end
    chk("single_latency", 32'(found), 32'h1);
    cycles(4);
    chk("single_pulses", chg_cnt - c0, 1);
    chk("single_evt", 32'({evt_if.evt_valid, evt_if.evt_data}), 32'h101);
    ack_pulse();
    chk("single_ack", 32'(evt_if.evt_valid), 32'h0);

    // Back to all off
    dip_pins = 8'hFF;
    cycles(20);
    ack_pulse();

    // Glitch: two ticks low is not enough
    c0 = chg_cnt;
    dip_pins = 8'hFE;
    cycles(8);
    dip_pins = 8'hFF;
    cycles(30);
    chk("glitch_sw", 32'(sw_val), 32'h00);
    chk("glitch_pulses", chg_cnt - c0, 0);

    // One-tick high blip restarts the count
    c0 = chg_cnt;
    dip_pins = 8'hFE;
    cycles(8);
    dip_pins = 8'hFF;
    cycles(4);
    dip_pins = 8'hFE;
    cycles(9);
    chk("blip_early", 32'(sw_val), 32'h00);
    cycles(21);
    chk("blip_sw", 32'(sw_val), 32'h01);
    chk("blip_pulses", chg_cnt - c0, 1);
    ack_pulse();

    // Overrun
    dip_pins = 8'hFF;
    cycles(20);
    ack_pulse();
    dip_pins = 8'hFE;
    cycles(20);
    dip_pins = 8'hFC;
    cycles(20);
    chk("ovr_evt", 32'({evt_if.evt_valid, evt_if.evt_overrun, evt_if.evt_data}), 32'h303);
    ack_pulse();
    chk("ovr_ack", 32'({evt_if.evt_valid, evt_if.evt_overrun}), 32'h0);

    // Ack coincident with an update while an event is pending
    dip_pins = 8'hFE;
    cycles(20);
    chk("coinc_pending", 32'({evt_if.evt_valid, evt_if.evt_data}), 32'h101);
    dip_pins = 8'hFC;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (will_upd()) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("coinc_found", 32'(found), 32'h1);
    ack_pulse();
    chk("coinc_evt", 32'({sw_changed, evt_if.evt_valid, evt_if.evt_overrun, evt_if.evt_data}), 32'h603);
    ack_pulse();

    // Reset mid-debounce
    dip_pins = 8'h7F;
    cycles(8);
    #1 rst_n = 1'b0;
    #1 chk("midrst_outs", 32'({sw_val, sw_changed, evt_if.evt_valid, evt_if.evt_data, evt_if.evt_overrun}), 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    c0 = chg_cnt;
    cycles(11);
    chk("midrst_early", 32'(sw_val), 32'h00);
    cycles(1);
    chk("midrst_sw", 32'(sw_val), 32'h80);
    cycles(10);
    chk("midrst_pulses", chg_cnt - c0, 1);
    chk("midrst_evt", 32'({evt_if.evt_valid, evt_if.evt_data}), 32'h180);
    ack_pulse();

    // Randomised phase
    for (int n = 0; n < 120; n++) begin
      int hold;
      dip_pins = 8'($urandom());
      if ($urandom_range(0, 3) != 0) dip_pins = dip_pins | 8'hF0;
      hold = $urandom_range(1, 24);
      for (int k = 0; k < hold; k++) begin
        evt_if.evt_ack = ($urandom_range(0, 2) == 0);
        @(negedge clk);
      end
    end
    evt_if.evt_ack = 1'b0;
    cycles(30);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
